reg_file_2r1w: RTL

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_rd_port.sv | 58 +++++
 rtl/reg_file_2r1w.sv | 92 +++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and the address-width helper for the 2-read/1-write register file.
package reg_file_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Smallest r with (1 << r) >= value; callers always pass value >= 2.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, write-first bypass, output register and valid flag.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Clear,
  input  logic                   RdEn,
  input  logic [ADDR_W-1:0]      RdAddr,
  input  logic [DEPTH*WIDTH-1:0] memFlat,
  input  logic                   wrFire,
  input  logic [ADDR_W-1:0]      WrAddr,
  input  logic [WIDTH-1:0]       WrData,
  output logic [WIDTH-1:0]       RdData,
  output logic                   RdValid,
  output logic                   rdErr
);

  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  logic              inRange;
  logic              bypass;
  logic [WIDTH-1:0]  storedWord;
  logic [WIDTH-1:0]  nextData;

  assign inRange = ({1'b0, RdAddr} < DepthLim);
  // wrFire already implies an in-range write address, so equality alone is enough.
  assign bypass  = wrFire && (WrAddr == RdAddr);
  assign rdErr   = RdEn && !inRange;

  always_comb begin
    storedWord = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (inRange && (int'(RdAddr) == i)) storedWord = memFlat[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    nextData = storedWord;
    if (Clear || !inRange) nextData = '0;
    else if (bypass)       nextData = WrData;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RdData  <= '0;
      RdValid <= 1'b0;
    end else begin
      RdValid <= RdEn;
      if (RdEn) RdData <= nextData;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with one write port and two independent registered read ports.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        Clear,
  input  logic                        WrEn,
  input  logic [clog2(DEPTH)-1:0]     WrAddr,
  input  logic [WIDTH-1:0]            WrData,
  input  logic                        RdEnA,
  input  logic                        RdEnB,
  input  logic [clog2(DEPTH)-1:0]     RdAddrA,
  input  logic [clog2(DEPTH)-1:0]     RdAddrB,
  output logic [WIDTH-1:0]            RdDataA,
  output logic [WIDTH-1:0]            RdDataB,
  output logic                        RdValidA,
  output logic                        RdValidB,
  output logic                        AddrErr
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]       regs [DEPTH];
  logic [DEPTH*WIDTH-1:0] memFlat;
  logic                   wrInRange;
  logic                   wrFire;
  logic                   wrErr;
  logic                   rdErrA;
  logic                   rdErrB;

  assign wrInRange = ({1'b0, WrAddr} < DepthLim);
  assign wrFire    = WrEn && !Clear && wrInRange;
  assign wrErr     = WrEn && !wrInRange;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (Clear) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wrFire) begin
      regs[WrAddr] <= WrData;
    end
  end

  always_comb begin
    memFlat = '0;
    for (int i = 0; i < DEPTH; i++) memFlat[i*WIDTH +: WIDTH] = regs[i];
  end

  // Clear wins over any error raised in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                          AddrErr <= 1'b0;
    else if (Clear)                    AddrErr <= 1'b0;
    else if (wrErr || rdErrA || rdErrB) AddrErr <= 1'b1;
  end

  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_a (
    .CLK     (CLK),
    .RST     (RST),
    .Clear   (Clear),
    .RdEn    (RdEnA),
    .RdAddr  (RdAddrA),
    .memFlat (memFlat),
    .wrFire  (wrFire),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .RdData  (RdDataA),
    .RdValid (RdValidA),
    .rdErr   (rdErrA)
  );

  reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_b (
    .CLK     (CLK),
    .RST     (RST),
    .Clear   (Clear),
    .RdEn    (RdEnB),
    .RdAddr  (RdAddrB),
    .memFlat (memFlat),
    .wrFire  (wrFire),
    .WrAddr  (WrAddr),
    .WrData  (WrData),
    .RdData  (RdDataB),
    .RdValid (RdValidB),
    .rdErr   (rdErrB)
  );

endmodule
